// File: rtl/arith_pkg.sv
// arith_pkg
// Shared definitions for the nibble-serial arithmetic sequencer:
//   NIBBLE      - width of the narrow adder datapath
//   state_t     - sequencer FSM encoding
//   step_count  - number of nibble steps for a given operand width
package arith_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int step_count(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/Adder.sv
// Adder
// 4-bit ripple-carry adder, the narrow datapath shared by wide sequencers.
// Ports:
//   x, y  in  4  addends
//   cin   in  1  carry in
//   s     out 4  sum bits
//   cout  out 1  carry out of bit 3
module Adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// WIDTH-bit add/subtract performed one nibble per cycle (LSB first) on a
// single 4-bit Adder, with the inter-nibble carry held in a flop.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     request handshake carrying a, b, sub
//   a, b                  operands (WIDTH bits), sub: 0 = a+b, 1 = a-b
//   out_valid/out_ready   result handshake
//   sum                   result modulo 2^WIDTH
//   cout                  final carry (subtract: 1 = no borrow)
//   ovf                   two's-complement overflow
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | one nibble step per cycle, idx selects the nibble
// DONE  | result held, out_valid high until out_ready
module nibble_serial_add_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = step_count(WIDTH);
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_width_check
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t state, state_nxt;

  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W+1:0]  base;
  logic [NIBBLE-1:0] add_x;
  logic [NIBBLE-1:0] add_y;
  logic [NIBBLE-1:0] add_s;
  logic              add_cout;
  logic              accept;
  logic              step;
  logic              last_step;

  // Bit offset of the current nibble: idx * 4 as a shift, no multiplier.
  assign base  = {idx, 2'b00};
  assign add_x = a_r[base +: NIBBLE];
  assign add_y = b_r[base +: NIBBLE];

  Adder u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (carry),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so a request is never advertised during reset.
        in_ready = ~rst;
        accept   = in_valid & ~rst;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        step      = 1'b1;
        last_step = (idx == LAST_IDX);
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        // Subtract as a + ~b + 1: the +1 rides in on the first carry.
        a_r   <= a;
        b_r   <= sub ? ~b : b;
        carry <= sub;
        idx   <= '0;
      end
      if (step) begin
        sum[base +: NIBBLE] <= add_s;
        carry               <= add_cout;
        idx                 <= last_step ? '0 : idx + 1'b1;
        if (last_step) begin
          cout <= add_cout;
          ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (add_s[NIBBLE-1] != a_r[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic res_t ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                     input logic rs);
    res_t r;
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ra);
    ub = int'(rb);
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (!rs) begin
      ur     = ua + ub;
      sr     = sa + sb;
      r.cout = (ur > 65535);
    end else begin
      ur     = ua - ub;
      sr     = sa - sb;
      r.cout = (ua >= ub);
    end
    r.sum = ur[15:0];
    r.ovf = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) check("in_ready_with_out_valid", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got sum %0h with empty queue", sum);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          check("sb_sum",  32'(sum),  32'(e.sum));
          check("sb_cout", 32'(cout), 32'(e.cout));
          check("sb_ovf",  32'(ovf),  32'(e.ovf));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                       output int acc);
    bit got;
    got      = 1'b0;
    acc      = -1;
    a        = ia;
    b        = ib;
    sub      = is;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_model(ia, ib, is));
        n_push++;
        acc = cyc + 1;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    sub      = 1'($urandom_range(0, 1));
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got no in_ready required accept");
    end
  endtask

  // Returns at the negedge where out_valid is first seen.
  task automatic wait_valid(output int vc);
    bit got;
    got = 1'b0;
    vc  = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        vc  = cyc;
        got = 1'b1;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL valid_timeout: got no out_valid required result");
    end
  endtask

  task automatic run_directed(input logic [15:0] ia, input logic [15:0] ib, input logic is,
                              input logic [15:0] esum, input logic ecout, input logic eovf);
    int acc, vc;
    issue(ia, ib, is, acc);
    wait_valid(vc);
    check("latency",   32'(vc - acc), 32'd4);
    check("dir_sum",   32'(sum),  32'(esum));
    check("dir_cout",  32'(cout), 32'(ecout));
    check("dir_ovf",   32'(ovf),  32'(eovf));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("in_ready_after_done", 32'(in_ready), 32'd1);
    check("out_valid_after_done", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          acc, vc, p0, q0;
    logic [15:0] ra, rb;
    logic        rs;
    bit          rand_done;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    run_directed(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_directed(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_directed(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Back-pressure with an intruding request.
    out_ready = 1'b0;
    issue(16'h7FFF, 16'h0001, 1'b0, acc);
    wait_valid(vc);
    check("bp_latency", 32'(vc - acc), 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = 16'($urandom);
      b        = 16'($urandom);
      sub      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_sum",       32'(sum),       32'h8000);
      check("bp_cout",      32'(cout),      32'd0);
      check("bp_ovf",       32'(ovf),       32'd1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_at_handshake", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_queue_drained",  32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset during the second RUN step.
    issue(16'hAAAA, 16'h5555, 1'b0, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_during", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_after", 32'(in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("midrst_no_output", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    run_directed(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Randomized back-to-back stream with random back-pressure.
    p0        = n_push;
    q0        = n_pop;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          ra = 16'($urandom);
          rb = 16'($urandom);
          rs = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) ra = 16'h8000;
          if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
          issue(ra, rb, rs, acc);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rand_pushed", 32'(n_push - p0), 32'd200);
    check("rand_popped", 32'(n_pop - q0),  32'd200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-multiplexing one instance of the team's existing 4-bit ripple `Adder` (x, y, cin, s, cout).
- It processes one nibble per cycle, least significant first, and holds the inter-nibble carry in a flop.
- It accepts operands over a valid/ready handshake and returns sum, carry-out and signed overflow over a second valid/ready handshake.
- It sits between an issuing controller and the narrow adder datapath, so wide arithmetic is possible without widening the adder.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 8.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request carries valid operands.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result registers hold a finished result.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  final carry; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  two's-complement overflow.

## Operation
- N = WIDTH/4 nibble steps. FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&in_ready, latch:
    - a_r ← a.
    - b_r ← sub ? ~b : b.
    - carry ← sub.
    - idx ← 0.
  - Then go to RUN.
- **RUN**
  - Drive Adder x=a_r[4·idx+:4], y=b_r[4·idx+:4], cin=carry.
  - Register s into sum[4·idx+:4]; carry ← Adder cout; idx ← idx+1.
  - On the step with idx==N−1:
    - cout ← Adder cout.
    - ovf ← (a_r[W−1]==b_r[W−1]) & (s[3]!=a_r[W−1]).
    - Go to DONE.
- **DONE**
  - out_valid=1. sum/cout/ovf are held stable.
  - When out_ready=1, go to IDLE.
- in_valid asserted outside IDLE is ignored. Requests are not queued, and the requester must hold its request until in_ready.
- a, b and sub are sampled only at the accept edge; later changes have no effect on the operation in flight.
- Width rules:
  - idx is clog2(N) bits.
  - sum, cout and ovf are registered outputs, updated only in RUN; a new accept does not clear them.

## Timing
- Reset (rst=1 at a rising edge) forces state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0.
- in_ready=0 while rst=1, and 1 in the first cycle after reset deasserts.
- Reset mid-RUN or mid-DONE aborts the operation with no output; the result is never presented.
- Latency: with accept at edge E0, the nibble steps occur at E1..EN and out_valid rises after EN. The result is visible N cycles after the accept edge.
- With out_ready held high, DONE lasts 1 cycle, and in_ready reasserts the cycle after. Back-to-back throughput is one operation per N+2 cycles.
- out_valid stays high and outputs stay unchanged for any number of cycles with out_ready=0.
- in_ready and out_valid are never high in the same cycle.

## Structure
- A shared package `arith_pkg` holds:
  - NIBBLE=4.
  - The FSM enum {IDLE, RUN, DONE}.
  - The helper function for the step count (WIDTH/NIBBLE).
- One sub-module is natural: the existing `Adder`, instantiated once as the only arithmetic. No other adders and no `+` on operands in this block.
- An elaboration-time check rejects WIDTH%4 != 0 or WIDTH<8.

## Test plan
All scenarios use WIDTH=16.
- 0x1234 + 0x0FFF, sub=0 -> sum=0x2233, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
- 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0. This exercises carry propagation through all 4 nibbles.
- 0x8000 − 0x0001 (sub=1) -> sum=0x7FFF, cout=1, ovf=1. Also 0x0003 − 0x0005 -> sum=0xFFFE, cout=0, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: sum, cout and ovf stay constant, and in_ready=0 throughout.
  - Required: a second in_valid with new operands during this time is ignored; the result is unchanged and in_ready returns only after the out_valid/out_ready handshake.
- Reset mid-operation: assert rst for 1 cycle during the 2nd RUN step.
  - Required: out_valid stays 0 and in_ready=1 the cycle after reset.
  - Required: the next request 0x0001+0x0001 yields 0x0002 with no stale carry.
- Randomized back-to-back stream of 200 ops with random out_ready -> every result matches the (a±b) mod 2^16 reference, with cout/ovf correct, and no request lost or duplicated.
